// File: rtl/pcie_fc_init_rx_if.sv
`default_nettype none
// pcie_fc_init_rx_if: AXI-stream bundle carrying received DLLPs, two beats per DLLP.
interface pcie_fc_init_rx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic [KEEP_WIDTH-1:0] s_axis_tkeep;
  logic                  s_axis_tvalid;
  logic                  s_axis_tlast;
  logic [USER_WIDTH-1:0] s_axis_tuser;
  logic                  s_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready
  );
endinterface
`default_nettype wire

// File: rtl/pcie_fc_init_rx.sv
`default_nettype none
// pcie_fc_init_rx: parses InitFC1/InitFC2/UpdateFC DLLPs, checks the 16-bit DLLP CRC
// and maintains the P/NP/Cpl header and data credit limits for VC0.
module pcie_fc_init_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fc_init_clear_i,
  pcie_fc_init_rx_if.slave       s_axis,
  output logic                   fc1_values_stored_o,
  output logic                   fc2_values_stored_o,
  output logic [7:0]             p_hdr_limit_o,
  output logic [7:0]             np_hdr_limit_o,
  output logic [7:0]             cpl_hdr_limit_o,
  output logic [11:0]            p_data_limit_o,
  output logic [11:0]            np_data_limit_o,
  output logic [11:0]            cpl_data_limit_o,
  output logic                   crc_err_o,
  output logic                   malformed_o
);

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_CRC  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // DLLP CRC: poly 0x100B, seed all-ones, bits fed from tdata[0] upward,
  // result bit-reversed within each byte to match the wire order.
  function automatic logic [15:0] dllp_crc(input logic [31:0] w);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ w[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h100B;
    end
    for (int i = 0; i < 8; i++) begin
      r[i]     = c[7-i];
      r[8+i]   = c[15-i];
    end
    return r;
  endfunction

  logic [1:0]            rst_sync_q;
  logic                  rst_int_n;
  logic [DATA_WIDTH-1:0] tdata;
  logic [31:0]           beat_w;
  logic                  beat_valid;
  logic [15:0]           crc_calc;
  logic [KEEP_WIDTH-1:0] unused_keep;
  logic [USER_WIDTH-1:0] unused_user;
  logic                  unused_bits;

  state_t                state_q;
  logic [7:0]            type_q;
  logic [7:0]            hdrfc_q;
  logic [11:0]           datafc_q;
  logic [15:0]           crc_q;
  logic [2:0][7:0]       hdr_lim_q;
  logic [2:0][11:0]      data_lim_q;
  logic [2:0]            seen_q;
  logic                  fc1_q;
  logic                  fc2_q;
  logic                  crc_err_q;
  logic                  malformed_q;

  logic [1:0]            type_idx;
  logic                  type_ok;
  logic                  is_init;
  logic                  is_upd;
  logic                  is_fc2_or_upd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n            = rst_sync_q[1];
  assign s_axis.s_axis_tready = rst_int_n;

  assign tdata       = s_axis.s_axis_tdata;
  assign beat_w      = tdata[31:0];
  assign beat_valid  = s_axis.s_axis_tvalid & rst_int_n;
  assign crc_calc    = dllp_crc(beat_w);
  assign unused_keep = s_axis.s_axis_tkeep;
  assign unused_user = s_axis.s_axis_tuser;
  assign unused_bits = ^{unused_keep, unused_user};

  // Only VC0 FC DLLPs with a P/NP/Cpl selector are acted upon; all else is ignored.
  assign type_idx      = type_q[5:4];
  assign type_ok       = (type_q[3:0] == 4'h0) && (type_idx != 2'b11) && (type_q[7:6] != 2'b00);
  assign is_init       = type_ok && type_q[6];
  assign is_upd        = type_ok && (type_q[7:6] == 2'b10);
  assign is_fc2_or_upd = type_ok && type_q[7];

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_HDR;
      type_q      <= 8'h00;
      hdrfc_q     <= 8'h00;
      datafc_q    <= 12'h000;
      crc_q       <= 16'h0000;
      hdr_lim_q   <= '0;
      data_lim_q  <= '0;
      seen_q      <= 3'b000;
      fc1_q       <= 1'b0;
      fc2_q       <= 1'b0;
      crc_err_q   <= 1'b0;
      malformed_q <= 1'b0;
    end else begin
      crc_err_q   <= 1'b0;
      malformed_q <= 1'b0;
      fc1_q       <= &seen_q;
      if (fc_init_clear_i) begin
        state_q    <= ST_HDR;
        hdr_lim_q  <= '0;
        data_lim_q <= '0;
        seen_q     <= 3'b000;
        fc1_q      <= 1'b0;
        fc2_q      <= 1'b0;
      end else if (beat_valid) begin
        case (state_q)
          ST_HDR: begin
            if (s_axis.s_axis_tlast) begin
              malformed_q <= 1'b1;
            end else begin
              type_q   <= beat_w[7:0];
              hdrfc_q  <= {beat_w[13:8], beat_w[23:22]};
              datafc_q <= {beat_w[19:16], beat_w[31:24]};
              crc_q    <= crc_calc;
              state_q  <= ST_CRC;
            end
          end
          ST_CRC: begin
            if (!s_axis.s_axis_tlast) begin
              malformed_q <= 1'b1;
              state_q     <= ST_DROP;
            end else begin
              state_q <= ST_HDR;
              if (crc_q != beat_w[15:0]) begin
                crc_err_q <= 1'b1;
              end else begin
                if (is_init && !seen_q[type_idx]) begin
                  hdr_lim_q[type_idx]  <= hdrfc_q;
                  data_lim_q[type_idx] <= datafc_q;
                  seen_q[type_idx]     <= 1'b1;
                end
                if (is_upd && fc2_q) begin
                  hdr_lim_q[type_idx]  <= hdrfc_q;
                  data_lim_q[type_idx] <= datafc_q;
                end
                if (is_fc2_or_upd && fc1_q) fc2_q <= 1'b1;
              end
            end
          end
          ST_DROP: begin
            if (s_axis.s_axis_tlast) state_q <= ST_HDR;
          end
          default: state_q <= ST_HDR;
        endcase
      end
    end
  end

  assign fc1_values_stored_o = fc1_q;
  assign fc2_values_stored_o = fc2_q;
  assign p_hdr_limit_o       = hdr_lim_q[0];
  assign np_hdr_limit_o      = hdr_lim_q[1];
  assign cpl_hdr_limit_o     = hdr_lim_q[2];
  assign p_data_limit_o      = data_lim_q[0];
  assign np_data_limit_o     = data_lim_q[1];
  assign cpl_data_limit_o    = data_lim_q[2];
  assign crc_err_o           = crc_err_q;
  assign malformed_o         = malformed_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_fc_init_rx.sv
`default_nettype none
// tb_pcie_fc_init_rx: vector table, directed corner sequences and a randomized
// phase checked against a credit-tracking reference model.
module tb_pcie_fc_init_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic        fc1, fc2, crc_err, malformed;
  logic [7:0]  p_hdr, np_hdr, cpl_hdr;
  logic [11:0] p_data, np_data, cpl_data;

  pcie_fc_init_rx_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3)) axis ();

  pcie_fc_init_rx #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .fc_init_clear_i     (clr),
    .s_axis              (axis),
    .fc1_values_stored_o (fc1),
    .fc2_values_stored_o (fc2),
    .p_hdr_limit_o       (p_hdr),
    .np_hdr_limit_o      (np_hdr),
    .cpl_hdr_limit_o     (cpl_hdr),
    .p_data_limit_o      (p_data),
    .np_data_limit_o     (np_data),
    .cpl_data_limit_o    (cpl_data),
    .crc_err_o           (crc_err),
    .malformed_o         (malformed)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC by polynomial division: (seed*x^32 + M*x^16) mod (x^16+x^12+x^3+x+1).
  function automatic logic [7:0] rev8(input logic [7:0] b);
    return {<<{b}};
  endfunction

  function automatic logic [15:0] crc_ref(input logic [31:0] w);
    logic [31:0] m;
    logic [63:0] v;
    for (int i = 0; i < 32; i++) m[31-i] = w[i];
    v = ({32'h0, m} << 16) ^ (64'hFFFF << 32);
    for (int k = 63; k >= 16; k--)
      if (v[k]) v = v ^ (64'h1100B << (k - 16));
    return {rev8(v[15:8]), rev8(v[7:0])};
  endfunction

  function automatic logic [31:0] hdr_word(input logic [7:0] b0, input logic [7:0] hdr,
                                           input logic [11:0] data);
    logic [1:0] r1, r2;
    r1 = 2'($urandom);
    r2 = 2'($urandom);
    return {data[7:0], hdr[1:0], r2, data[11:8], r1, hdr[7:2], b0};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    axis.s_axis_tdata  = d;
    axis.s_axis_tkeep  = k;
    axis.s_axis_tlast  = l;
    axis.s_axis_tuser  = 3'($urandom);
    axis.s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tdata  = $urandom;
    axis.s_axis_tlast  = 1'($urandom);
  endtask

  task automatic send_dllp(input logic [7:0] b0, input logic [7:0] hdr, input logic [11:0] data,
                           input bit bad, input int gap);
    logic [31:0] w;
    logic [15:0] c;
    w = hdr_word(b0, hdr, data);
    beat(w, 4'hF, 1'b0);
    if (gap > 0) idle(gap);
    c = crc_ref(w) ^ {15'h0, bad};
    beat({16'($urandom), c}, 4'h3, 1'b1);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_hdr [3];
  logic [11:0] m_data[3];
  bit          m_seen[3];
  bit          m_fc1, m_fc2;

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_hdr[i] = 8'h00; m_data[i] = 12'h000; m_seen[i] = 1'b0;
    end
    m_fc1 = 1'b0;
    m_fc2 = 1'b0;
  endtask

  task automatic m_commit(input logic [7:0] b0, input logic [7:0] hdr, input logic [11:0] data);
    bit init, upd, fc2ish;
    int x;
    init   = b0 inside {8'h40, 8'h50, 8'h60, 8'hC0, 8'hD0, 8'hE0};
    upd    = b0 inside {8'h80, 8'h90, 8'hA0};
    fc2ish = b0 inside {8'hC0, 8'hD0, 8'hE0, 8'h80, 8'h90, 8'hA0};
    x = (b0 >> 4) % 4;
    if (init && !m_seen[x]) begin
      m_hdr[x] = hdr; m_data[x] = data; m_seen[x] = 1'b1;
    end
    if (upd && m_fc2) begin
      m_hdr[x] = hdr; m_data[x] = data;
    end
    if (fc2ish && m_fc1) m_fc2 = 1'b1;
  endtask

  task automatic check_model(input string tag, input bit exp_crc, input bit exp_mal, input bit fc1_now);
    chk({tag, " p_hdr"},    32'(p_hdr),    32'(m_hdr[0]));
    chk({tag, " np_hdr"},   32'(np_hdr),   32'(m_hdr[1]));
    chk({tag, " cpl_hdr"},  32'(cpl_hdr),  32'(m_hdr[2]));
    chk({tag, " p_data"},   32'(p_data),   32'(m_data[0]));
    chk({tag, " np_data"},  32'(np_data),  32'(m_data[1]));
    chk({tag, " cpl_data"}, 32'(cpl_data), 32'(m_data[2]));
    chk({tag, " fc2"},      32'(fc2),      32'(m_fc2));
    chk({tag, " fc1"},      32'(fc1),      32'(fc1_now));
    chk({tag, " crc_err"},  32'(crc_err),  32'(exp_crc));
    chk({tag, " malformed"},32'(malformed),32'(exp_mal));
  endtask

  // Send one DLLP, check the commit edge, then one idle cycle for fc1 to follow.
  task automatic model_dllp(input string tag, input logic [7:0] b0, input logic [7:0] hdr,
                            input logic [11:0] data, input bit bad, input int gap);
    bit fc1_now;
    send_dllp(b0, hdr, data, bad, gap);
    fc1_now = m_fc1;
    if (!bad) m_commit(b0, hdr, data);
    check_model(tag, bad, 1'b0, fc1_now);
    idle(1);
    m_fc1 = m_seen[0] && m_seen[1] && m_seen[2];
    chk({tag, " fc1 next"}, 32'(fc1), 32'(m_fc1));
    chk({tag, " crc_err next"}, 32'(crc_err), 32'h0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " limits"}, 32'({p_hdr, np_hdr, cpl_hdr} | 24'({p_data, np_data, cpl_data} != 0)), 32'h0);
    chk({tag, " flags"},  32'({fc1, fc2, crc_err, malformed}), 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  hdr;
    logic [11:0] data;
    bit          bad;
    logic [7:0]  ph, nph, ch;
    logic [11:0] pd, npd, cd;
    bit          e_fc1, e_fc2, e_crc;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] hdr, input logic [11:0] data,
                              input bit bad, input logic [7:0] ph, input logic [11:0] pd,
                              input logic [7:0] nph, input logic [11:0] npd,
                              input logic [7:0] ch, input logic [11:0] cd,
                              input bit f1, input bit f2, input bit ce);
    vec_t v;
    v.b0 = b0; v.hdr = hdr; v.data = data; v.bad = bad;
    v.ph = ph; v.pd = pd; v.nph = nph; v.npd = npd; v.ch = ch; v.cd = cd;
    v.e_fc1 = f1; v.e_fc2 = f2; v.e_crc = ce;
    return v;
  endfunction

  initial begin
    logic [31:0] w;
    logic [15:0] c;

    axis.s_axis_tdata  = '0;
    axis.s_axis_tkeep  = '0;
    axis.s_axis_tlast  = 1'b0;
    axis.s_axis_tuser  = '0;
    axis.s_axis_tvalid = 1'b0;

    //          b0     hdr    data   bad  P hdr/data     NP hdr/data    Cpl hdr/data  fc1 fc2 crc
    tbl[0]  = mk(8'h40, 8'h20, 12'h010, 0, 8'h20, 12'h010, 8'h00, 12'h000, 8'h00, 12'h000, 0, 0, 0);
    tbl[1]  = mk(8'h50, 8'h11, 12'h123, 1, 8'h20, 12'h010, 8'h00, 12'h000, 8'h00, 12'h000, 0, 0, 1);
    tbl[2]  = mk(8'h50, 8'h20, 12'h020, 0, 8'h20, 12'h010, 8'h20, 12'h020, 8'h00, 12'h000, 0, 0, 0);
    tbl[3]  = mk(8'h40, 8'h55, 12'h555, 0, 8'h20, 12'h010, 8'h20, 12'h020, 8'h00, 12'h000, 0, 0, 0);
    tbl[4]  = mk(8'h80, 8'hAA, 12'hABC, 0, 8'h20, 12'h010, 8'h20, 12'h020, 8'h00, 12'h000, 0, 0, 0);
    tbl[5]  = mk(8'h60, 8'h00, 12'h000, 0, 8'h20, 12'h010, 8'h20, 12'h020, 8'h00, 12'h000, 1, 0, 0);
    tbl[6]  = mk(8'hC0, 8'h77, 12'h777, 0, 8'h20, 12'h010, 8'h20, 12'h020, 8'h00, 12'h000, 1, 1, 0);
    tbl[7]  = mk(8'h80, 8'h30, 12'h040, 0, 8'h30, 12'h040, 8'h20, 12'h020, 8'h00, 12'h000, 1, 1, 0);
    tbl[8]  = mk(8'h40, 8'h66, 12'h666, 1, 8'h30, 12'h040, 8'h20, 12'h020, 8'h00, 12'h000, 1, 1, 1);
    tbl[9]  = mk(8'h41, 8'h12, 12'h345, 0, 8'h30, 12'h040, 8'h20, 12'h020, 8'h00, 12'h000, 1, 1, 0);
    tbl[10] = mk(8'hA0, 8'h05, 12'h006, 0, 8'h30, 12'h040, 8'h20, 12'h020, 8'h05, 12'h006, 1, 1, 0);
    tbl[11] = mk(8'h91, 8'h7F, 12'hFFF, 0, 8'h30, 12'h040, 8'h20, 12'h020, 8'h05, 12'h006, 1, 1, 0);
    tbl[12] = mk(8'hD0, 8'h99, 12'h999, 0, 8'h30, 12'h040, 8'h20, 12'h020, 8'h05, 12'h006, 1, 1, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset tready", 32'(axis.s_axis_tready), 32'h0);
    check_zero("reset");
    rst_n = 1'b1;
    idle(1);
    chk("sync tready edge1", 32'(axis.s_axis_tready), 32'h0);
    idle(1);
    chk("sync tready edge2", 32'(axis.s_axis_tready), 32'h1);

    for (int i = 0; i < 13; i++) begin
      send_dllp(tbl[i].b0, tbl[i].hdr, tbl[i].data, tbl[i].bad, i % 3);
      chk($sformatf("vec%0d crc_err", i), 32'(crc_err), 32'(tbl[i].e_crc));
      chk($sformatf("vec%0d malformed", i), 32'(malformed), 32'h0);
      chk($sformatf("vec%0d p", i),   {p_hdr, 12'h0, p_data},     {tbl[i].ph, 12'h0, tbl[i].pd});
      chk($sformatf("vec%0d np", i),  {np_hdr, 12'h0, np_data},   {tbl[i].nph, 12'h0, tbl[i].npd});
      chk($sformatf("vec%0d cpl", i), {cpl_hdr, 12'h0, cpl_data}, {tbl[i].ch, 12'h0, tbl[i].cd});
      chk($sformatf("vec%0d fc2", i), 32'(fc2), 32'(tbl[i].e_fc2));
      idle(1);
      chk($sformatf("vec%0d fc1", i), 32'(fc1), 32'(tbl[i].e_fc1));
      chk($sformatf("vec%0d crc_err pulse", i), 32'(crc_err), 32'h0);
    end

    // Clear coincident with a CRC beat: discarded, everything zero.
    w = hdr_word(8'h40, 8'h44, 12'h444);
    beat(w, 4'hF, 1'b0);
    clr = 1'b1;
    beat({16'h0, crc_ref(w)}, 4'h3, 1'b1);
    clr = 1'b0;
    check_zero("clear");
    idle(1);
    check_zero("clear+1");
    m_reset();
    model_dllp("post-clear P", 8'h40, 8'h44, 12'h444, 1'b0, 0);

    // Header beat with tlast=1, then a good DLLP.
    beat(hdr_word(8'h50, 8'h01, 12'h001), 4'hF, 1'b1);
    chk("lone hdr malformed", 32'(malformed), 32'h1);
    idle(1);
    chk("lone hdr malformed pulse", 32'(malformed), 32'h0);
    model_dllp("after lone hdr", 8'h50, 8'h21, 12'h0AB, 1'b0, 1);

    // Two header beats then a CRC beat: one malformed pulse, no commit.
    w = hdr_word(8'h60, 8'h33, 12'h033);
    beat(w, 4'hF, 1'b0);
    beat(w, 4'hF, 1'b0);
    chk("double hdr malformed", 32'(malformed), 32'h1);
    beat({16'h0, crc_ref(w)}, 4'h3, 1'b1);
    check_model("drop crc beat", 1'b0, 1'b0, m_fc1);
    model_dllp("after drop", 8'h60, 8'h33, 12'h033, 1'b0, 2);

    // Reset mid-DLLP.
    beat(hdr_word(8'hC0, 8'h12, 12'h034), 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    chk("async reset tready", 32'(axis.s_axis_tready), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("rerelease tready", 32'(axis.s_axis_tready), 32'h1);
    m_reset();
    w = hdr_word(8'hC0, 8'h12, 12'h034);
    beat({16'h0, crc_ref(w)}, 4'h3, 1'b1);
    check_model("partial discarded", 1'b0, 1'b1, 1'b0);
    idle(1);

    // Randomized phase against the model.
    for (int n = 0; n < 160; n++) begin
      logic [7:0] b0;
      int sel;
      if ($urandom_range(0, 39) == 0) begin
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        m_reset();
        check_zero($sformatf("rnd%0d clear", n));
        continue;
      end
      sel = $urandom_range(0, 10);
      case (sel)
        0: b0 = 8'h40;  1: b0 = 8'h50;  2: b0 = 8'h60;
        3: b0 = 8'hC0;  4: b0 = 8'hD0;  5: b0 = 8'hE0;
        6: b0 = 8'h80;  7: b0 = 8'h90;  8: b0 = 8'hA0;
        default: b0 = 8'($urandom);
      endcase
      model_dllp($sformatf("rnd%0d b0=%0h", n, b0), b0, 8'($urandom), 12'($urandom),
                 ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcie_fc_init_rx.md
PCIE_FC_INIT_RX -- requirements
Module: pcie_fc_init_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the DLLP AXIS data width; only 32 is supported.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, the tkeep width.
REQ-003 SHALL have parameter USER_WIDTH, default 3, the tuser width; tuser is ignored.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have clk_i  input  1  clock.
REQ-006 SHALL have rst_ni  input  1  async active-low reset.
REQ-007 SHALL have fc_init_clear_i  input  1  sync clear of all credit state (link down).
REQ-008 SHALL have s_axis_tdata/tkeep/tvalid/tlast/tuser  input  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH  received DLLP stream.
REQ-009 SHALL have s_axis_tready  output  1  stream ready.
REQ-010 SHALL have fc1_values_stored_o  output  1  InitFC1 P, NP and Cpl all captured.
REQ-011 SHALL have fc2_values_stored_o  output  1  FC_INIT2 complete.
REQ-012 SHALL have {p,np,cpl}_hdr_limit_o  output  8 each  header credit limits.
REQ-013 SHALL have {p,np,cpl}_data_limit_o  output  12 each  data credit limits.
REQ-014 SHALL have crc_err_o and malformed_o  output  1 each  one-cycle error pulses.

Function
REQ-015 SHALL accept a DLLP as two beats: header beat (tlast=0, tkeep=4'hF), then CRC beat (tlast=1, tkeep=4'h3, CRC in tdata[15:0]).
REQ-016 SHALL decode header byte0 = tdata[7:0] as follows: 0x40/0x50/0x60 InitFC1 P/NP/Cpl; 0xC0/0xD0/0xE0 InitFC2 P/NP/Cpl; 0x80/0x90/0xA0 UpdateFC P/NP/Cpl (VC0 only).
REQ-017 SHALL take any other type, including non-zero VC bits, as valid but ignored, with no error.
REQ-018 SHALL extract fields with byte1 = tdata[15:8], byte2 = tdata[23:16], byte3 = tdata[31:24].
REQ-019 SHALL form HdrFC = {byte1[5:0], byte2[7:6]} and DataFC = {byte2[3:0], byte3}.
REQ-020 SHALL compute the CRC over the 32-bit header beat with the existing pcie_datalink_crc instance, crcIn all-ones.
REQ-021 SHALL bit-reverse the computed CRC within each byte and require it to equal the received tdata[15:0].
REQ-022 SHALL implement FSM states: ST_HDR (await header), ST_CRC (await CRC), ST_DROP (discard until tlast).
REQ-023 In ST_HDR, a beat with tlast=0 SHALL register type/HdrFC/DataFC/CRC and move to ST_CRC.
REQ-024 In ST_HDR, a beat with tlast=1 SHALL pulse malformed_o and stay in ST_HDR.
REQ-025 In ST_CRC, a beat with tlast=1 and a good CRC SHALL commit the DLLP and return to ST_HDR.
REQ-026 In ST_CRC, a beat with tlast=1 and a bad CRC SHALL pulse crc_err_o, commit nothing, and return to ST_HDR.
REQ-027 In ST_CRC, a beat with tlast=0 SHALL pulse malformed_o and move to ST_DROP.
REQ-028 ST_DROP SHALL return to ST_HDR on the first accepted beat with tlast=1.
REQ-029 A committed InitFC1 or InitFC2 of type X SHALL load the X limits and set flag seen_X, but only if seen_X is 0; repeats are ignored.
REQ-030 fc1_values_stored_o SHALL be the registered AND of seen_P, seen_NP and seen_Cpl, asserted the cycle after the last commit.
REQ-031 fc2_values_stored_o SHALL set the cycle after a committed InitFC2 or UpdateFC (any type) while fc1_values_stored_o=1.
REQ-032 fc2_values_stored_o SHALL stay set until clear or reset.
REQ-033 A committed UpdateFC of type X SHALL overwrite the X limits only when fc2_values_stored_o=1; otherwise it only contributes to REQ-031.
REQ-034 Limit value 0 (infinite credit) SHALL be stored unmodified.
REQ-035 s_axis_tready SHALL be 1 whenever out of reset; the block never backpressures.
REQ-036 Commit latency SHALL be exactly 1 cycle: limits and flags update on the clock edge following the accepted CRC beat.
REQ-037 fc_init_clear_i=1 SHALL zero all limits, seen flags and both stored outputs, and force ST_HDR.
REQ-038 A beat coincident with fc_init_clear_i SHALL be discarded, with no commit and no error pulse.
REQ-039 tvalid=0 cycles between the two beats SHALL be tolerated with no timeout.

Reset
REQ-040 On rst_ni=0, the FSM SHALL go to ST_HDR and all limits, flags, crc_err_o, malformed_o, fc1_values_stored_o and fc2_values_stored_o SHALL be 0.
REQ-041 s_axis_tready SHALL be 0 while rst_ni=0.
REQ-042 Reset assertion mid-DLLP SHALL discard the partial DLLP.
REQ-043 Deassertion SHALL be synchronised internally; the block is functional from the second clock after deassertion.

Verification
REQ-044 Send good InitFC1 P(Hdr 0x20, Data 0x010), NP(0x20, 0x020), Cpl(0x00, 0x000) -> fc1_values_stored_o=1 one cycle after the Cpl CRC beat; p_hdr_limit_o=0x20, p_data_limit_o=0x010, np_data_limit_o=0x020, cpl limits 0.
REQ-045 Then send InitFC2 P -> fc2_values_stored_o=1 next cycle; p limits unchanged; UpdateFC P(Hdr 0x30, Data 0x040) -> p_hdr_limit_o=0x30, p_data_limit_o=0x040.
REQ-046 Send InitFC1 P with CRC bit 0 flipped -> crc_err_o pulses 1 cycle; limits and seen_P unchanged.
REQ-047 Send a header beat with tlast=1 -> malformed_o pulses; a following good DLLP is captured normally.
REQ-048 Send two header beats, then a CRC beat -> malformed_o pulses once; nothing committed; a following good DLLP is captured.
REQ-049 With both stored flags set, pulse fc_init_clear_i coincident with a CRC beat -> all outputs 0 next cycle, no commit; then assert rst_ni=0 mid-DLLP -> same all-zero state.
